sa_os_tile: RTL and testbench
=============================

SA_OS_TILE -- requirements
Module: sa_os_tile

Interface
REQ-001 SHALL have parameter N, default 8, array dimension (rows = columns = PEs per side, N >= 2).
REQ-002 SHALL have parameter DATA_W, default 8, operand width.
REQ-003 SHALL have parameter ACC_W, default 32, accumulator/result width (ACC_W >= 2*DATA_W).
REQ-004 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, an operand beat is present.
REQ-008 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 SHALL have port in_last, input, 1, the accepted beat is the final k-step of the tile.
REQ-010 SHALL have port a_col, input, [N][DATA_W], a_col[i] = A[i][k].
REQ-011 SHALL have port b_row, input, [N][DATA_W], b_row[j] = B[k][j].
REQ-012 SHALL have port out_valid, output, 1, result row present.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the row.
REQ-014 SHALL have port out_row, output, [N][ACC_W], out_row[j] = C[out_row_idx][j].
REQ-015 SHALL have port out_row_idx, output, clog2(N), index of presented row.
REQ-016 SHALL have port busy, output, 1, high whenever state != IDLE.

Function
REQ-017 SHALL compute C = A x B over any K >= 1 beats, output-stationary: PE(i,j) holds C[i][j].
REQ-018 SHALL skew internally: a_col[i] delayed i cycles, b_row[j] delayed j cycles; caller supplies unskewed vectors.
REQ-019 SHALL inject zeros into skew stage 0 on any cycle without an accepted beat (bubbles contribute nothing).
REQ-020 SHALL form each product at 2*DATA_W, extend (sign if SIGNED=1, else zero) to ACC_W, accumulate modulo 2^ACC_W (wrap, no saturation).
REQ-021 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
REQ-022 IDLE: in_ready=1; accepted beat with in_last=0 -> LOAD; with in_last=1 -> FLUSH.
REQ-023 LOAD: in_ready=1; in_valid low holds LOAD; accepted beat with in_last=1 -> FLUSH.
REQ-024 FLUSH: in_ready=0; lasts exactly 2N-1 cycles (counter), then DRAIN.
REQ-025 DRAIN: in_ready=0, out_valid=1; out_row_idx starts 0, increments on out_valid&&out_ready; row N-1 handshake -> IDLE.
REQ-026 SHALL hold out_row and out_row_idx stable while out_valid=1 and out_ready=0.
REQ-027 SHALL clear all accumulators on the final DRAIN handshake, so the next tile starts from zero.
REQ-028 SHALL ignore in_valid, in_last, a_col, b_row when in_ready=0.
REQ-029 out_row SHALL be 0 whenever out_valid=0.
REQ-030 in_last asserted with in_valid=0 SHALL have no effect.

Reset
REQ-031 rst high SHALL asynchronously force: state IDLE, accumulators, skew registers and FLUSH counter 0, out_valid=0, out_row_idx=0, out_row=0, busy=0.
REQ-032 in_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-033 rst asserted in any state (including mid-LOAD/FLUSH/DRAIN) SHALL discard the tile; the next tile SHALL compute correctly.

Verification
REQ-034 N=3, SIGNED=0, A=[[1,2,3],[4,5,6],[7,8,9]], B=[[10,11,12],[13,14,15],[16,17,18]], 3 back-to-back beats, out_ready=1 -> FLUSH 5 cycles, rows [84,90,96],[201,216,231],[318,342,366], idx 0,1,2, then IDLE.
REQ-035 Same tile, in_valid low 2 cycles between beats 1 and 2 -> identical results.
REQ-036 Same tile, out_ready low 5 cycles while idx=1 -> row [201,216,231] held stable, no rows lost/duplicated.
REQ-037 SIGNED=1, DATA_W=8, K=1, all operands -128 -> every C = 16384; SIGNED=0, all 255 -> 65025; ACC_W=16, K=2 all 255 -> 64514 (wrap).
REQ-038 rst pulse during FLUSH -> all outputs 0, in_ready=1 after release; REQ-034 tile rerun gives correct rows.
REQ-039 Single beat with in_last=1 from IDLE -> direct to FLUSH; C[i][j] = a_col[i]*b_row[j].

Source files
------------

// File: rtl/sa_os_tile.sv
`default_nettype none
// sa_os_tile: N x N output-stationary systolic matrix-multiply tile with internal
// operand skew, LOAD/FLUSH/DRAIN sequencing and a row-at-a-time result port.
module sa_os_tile #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [DATA_W-1:0]         a_col [N],
  input  logic [DATA_W-1:0]         b_row [N],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_row [N],
  output logic [$clog2(N)-1:0]      out_row_idx,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;
  logic               ready_q;
  logic [IDX_W-1:0]   row_idx;
  logic               accept;
  logic               last_row;
  logic               drain_done;

  // ready_q resets high; gating with rst keeps in_ready low only while reset is held
  assign in_ready    = ready_q & ~rst;
  assign accept      = in_valid & in_ready;
  assign last_row    = (row_idx == IDX_W'(N - 1));
  assign drain_done  = out_valid & out_ready & last_row;
  assign out_row_idx = row_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      ready_q   <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      row_idx   <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            busy <= 1'b1;
            if (in_last) begin
              state     <= FLUSH;
              ready_q   <= 1'b0;
              flush_cnt <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == CNT_W'(2 * N - 2)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_row) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              ready_q   <= 1'b1;
              row_idx   <= '0;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] a_sk [N];
  logic [DATA_W-1:0] b_sk [N];

  // Row/column i sees its operand i cycles after stage 0; bubbles load zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_d [0:i];
    logic [DATA_W-1:0] b_d [0:i];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) begin
          a_d[s] <= '0;
          b_d[s] <= '0;
        end
      end else begin
        a_d[0] <= accept ? a_col[i] : '0;
        b_d[0] <= accept ? b_row[i] : '0;
        for (int s = 1; s <= i; s++) begin
          a_d[s] <= a_d[s-1];
          b_d[s] <= b_d[s-1];
        end
      end
    end
    assign a_sk[i] = a_d[i];
    assign b_sk[i] = b_d[i];
  end

  logic [DATA_W-1:0] a_pipe [N][N-1];
  logic [DATA_W-1:0] b_pipe [N-1][N];
  logic [ACC_W-1:0]  acc    [N][N];

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      logic [DATA_W-1:0] a_in;
      logic [DATA_W-1:0] b_in;
      logic [ACC_W-1:0]  prod_x;
      logic [ACC_W-1:0]  acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in = a_sk[i];
      end else begin : g_a_int
        assign a_in = a_pipe[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = b_sk[j];
      end else begin : g_b_int
        assign b_in = b_pipe[i-1][j];
      end

      // Product is exact at 2*DATA_W; extension to ACC_W follows operand signedness.
      if (SIGNED != 0) begin : g_sgn
        logic signed [2*DATA_W-1:0] p;
        assign p      = (2*DATA_W)'($signed(a_in)) * (2*DATA_W)'($signed(b_in));
        assign prod_x = ACC_W'(p);
      end else begin : g_uns
        logic [2*DATA_W-1:0] p;
        assign p      = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
        assign prod_x = ACC_W'(p);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_q <= '0;
        end else if (drain_done) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_q + prod_x;
        end
      end
      assign acc[i][j] = acc_q;

      if (j < N - 1) begin : g_a_fwd
        logic [DATA_W-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) a_q <= '0;
          else     a_q <= a_in;
        end
        assign a_pipe[i][j] = a_q;
      end

      if (i < N - 1) begin : g_b_fwd
        logic [DATA_W-1:0] b_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) b_q <= '0;
          else     b_q <= b_in;
        end
        assign b_pipe[i][j] = b_q;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      out_row[j] = out_valid ? acc[row_idx][j] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_os_tile.sv
`default_nettype none
// tb_sa_os_tile: directed and random tiles checked against a plain matrix-product
// scoreboard, plus two small instances for signed and wrap-around corners.
module tb_sa_os_tile;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [DW-1:0] a_col [N];
  logic [DW-1:0] b_row [N];
  logic [AW-1:0] out_row [N];
  logic [1:0]    out_row_idx;

  sa_os_tile #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .busy(busy));

  logic        s_valid, s_last;
  logic [7:0]  s_a [2];
  logic [7:0]  s_b [2];
  logic        s_ready_s, s_ready_w, s_ov_s, s_ov_w, s_busy_s, s_busy_w, s_idx_s, s_idx_w;
  logic [31:0] s_row [2];
  logic [15:0] w_row [2];

  sa_os_tile #(.N(2), .DATA_W(8), .ACC_W(32), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready_s), .in_last(s_last),
    .a_col(s_a), .b_row(s_b), .out_valid(s_ov_s), .out_ready(1'b1),
    .out_row(s_row), .out_row_idx(s_idx_s), .busy(s_busy_s));

  sa_os_tile #(.N(2), .DATA_W(8), .ACC_W(16), .SIGNED(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready_w), .in_last(s_last),
    .a_col(s_a), .b_row(s_b), .out_valid(s_ov_w), .out_ready(1'b1),
    .out_row(w_row), .out_row_idx(s_idx_w), .busy(s_busy_w));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: matrices and a queue of expected result rows.
  int            A [N][8];
  int            B [8][N];
  logic [N*AW-1:0] exp_v [$];
  int            exp_i [$];
  logic [AW-1:0] cap [N][N];
  bit            chk_on = 1'b0;

  task automatic push_expect(input int K);
    logic [N*AW-1:0] row;
    logic [AW-1:0]   s;
    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < K; k++) s = s + AW'(A[i][k] * B[k][j]);
        row[j*AW +: AW] = s;
      end
      exp_v.push_back(row);
      exp_i.push_back(i);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      if (out_valid) begin
        if (exp_v.size() == 0) begin
          chk("row without expectation", 64'(exp_v.size()), 1);
        end else begin
          chk("row index", 64'(out_row_idx), 64'(exp_i[0]));
          for (int j = 0; j < N; j++) chk("row data", out_row[j], exp_v[0][j*AW +: AW]);
          if (out_ready) begin
            for (int j = 0; j < N; j++) cap[out_row_idx][j] = out_row[j];
            void'(exp_v.pop_front());
            void'(exp_i.pop_front());
          end
        end
      end else begin
        for (int j = 0; j < N; j++) chk("row zero when not valid", out_row[j], 0);
      end
    end
  end

  int rdy_mode  = 0;
  bit man_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 2) out_ready = man_ready;
    else                    out_ready = 1'b1;
  end

  task automatic idle_drive();
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) begin
      a_col[i] = 8'($urandom);
      b_row[i] = 8'($urandom);
    end
  endtask

  task automatic send_tile(input int K, input int gap_max, input int gap_at);
    int w;
    int g;
    bit ok;
    push_expect(K);
    for (int k = 0; k < K; k++) begin
      g = (k == gap_at) ? 2 : int'($urandom_range(0, gap_max));
      for (int c = 0; c < g; c++) begin
        idle_drive();
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_last  = (k == K - 1);
      for (int i = 0; i < N; i++) begin
        a_col[i] = DW'(A[i][k]);
        b_row[i] = DW'(B[k][i]);
      end
      w = 0;
      forever begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        if (ok) break;
        w++;
        if (w > 300) begin
          chk("beat accepted within budget", 64'(w), 0);
          break;
        end
      end
    end
    idle_drive();
  endtask

  task automatic count_flush(output int c);
    c = 0;
    @(negedge clk);
    while (!out_valid && c < 50) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("tile completes", busy, 0);
    chk("in_ready when idle", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_ref();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = 1 + 3 * i + k;
        B[k][i] = 10 + 3 * k + i;
      end
  endtask

  int ref034 [9] = '{84, 90, 96, 201, 216, 231, 318, 342, 366};

  task automatic check_ref_caps();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("reference tile element", cap[i][j], 64'(ref034[i*N+j]));
  endtask

  task automatic run_small(input logic [7:0] v, input int K, input logic [31:0] exp_s,
                           input logic [15:0] exp_w);
    int w;
    s_a = '{v, v};
    s_b = '{v, v};
    for (int k = 0; k < K; k++) begin
      chk("small in_ready", s_ready_s, 1);
      chk("small wrap in_ready", s_ready_w, 1);
      s_valid = 1'b1;
      s_last  = (k == K - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    w = 0;
    @(negedge clk);
    while (!s_ov_s && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("small drain reached", s_ov_s, 1);
    for (int r = 0; r < 2; r++) begin
      chk("small wrap valid", s_ov_w, 1);
      chk("small row idx", s_idx_s, 64'(r));
      chk("small wrap row idx", s_idx_w, 64'(r));
      for (int j = 0; j < 2; j++) begin
        chk("signed result", s_row[j], exp_s);
        chk("wrap result", w_row[j], exp_w);
      end
      @(negedge clk);
    end
    chk("small back to idle", s_busy_s, 0);
    chk("small wrap back to idle", s_busy_w, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl;
    int w;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_a = '{8'd0, 8'd0};
    s_b = '{8'd0, 8'd0};
    for (int i = 0; i < N; i++) begin
      a_col[i] = '0;
      b_row[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_row_idx", out_row_idx, 0);
    chk("reset out_row", out_row[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after release", in_ready, 1);
    @(posedge clk); #1;
    chk_on = 1'b1;

    // Reference tile, back-to-back beats
    load_ref();
    send_tile(3, 0, -1);
    count_flush(fl);
    chk("flush length", 64'(fl), 5);
    wait_idle();
    check_ref_caps();

    // Two bubble cycles between beats 1 and 2
    load_ref();
    send_tile(3, 0, 1);
    wait_idle();
    check_ref_caps();

    // Consumer stall on row 1
    rdy_mode = 2;
    man_ready = 1'b1;
    load_ref();
    send_tile(3, 0, -1);
    w = 0;
    @(negedge clk);
    while (!(out_valid && out_row_idx == 2'd0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    man_ready = 1'b0;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall holds row 1", out_row_idx, 1);
      chk("stall keeps valid", out_valid, 1);
      chk("stall holds data", out_row[1], 216);
    end
    man_ready = 1'b1;
    wait_idle();
    check_ref_caps();
    rdy_mode = 0;

    // Unsigned full-scale single beat
    for (int i = 0; i < N; i++) begin
      A[i][0] = 255;
      B[0][i] = 255;
    end
    send_tile(1, 0, -1);
    wait_idle();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("full-scale product", cap[i][j], 65025);

    // Single random beat goes straight to FLUSH
    for (int i = 0; i < N; i++) begin
      A[i][0] = int'($urandom_range(0, 255));
      B[0][i] = int'($urandom_range(0, 255));
    end
    send_tile(1, 0, -1);
    count_flush(fl);
    chk("single-beat flush length", 64'(fl), 5);
    wait_idle();

    // Reset in the middle of FLUSH discards the tile
    load_ref();
    send_tile(3, 0, -1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_v.delete();
    exp_i.delete();
    chk("mid-flush reset out_valid", out_valid, 0);
    chk("mid-flush reset busy", busy, 0);
    chk("mid-flush reset in_ready", in_ready, 0);
    chk("mid-flush reset idx", out_row_idx, 0);
    chk("mid-flush reset out_row", out_row[2], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after mid-flush reset", in_ready, 1);
    @(posedge clk); #1;
    load_ref();
    send_tile(3, 0, -1);
    wait_idle();
    check_ref_caps();

    // Signed and wrap-around corners on the 2x2 instances
    run_small(8'h80, 1, 32'd16384, 16'd16384);
    run_small(8'hFF, 2, 32'd2, 16'd64514);

    // Random tiles with bubbles and random consumer back-pressure
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int K;
      K = int'($urandom_range(1, 6));
      for (int i = 0; i < N; i++)
        for (int k = 0; k < K; k++) begin
          A[i][k] = int'($urandom_range(0, 255));
          B[k][i] = int'($urandom_range(0, 255));
        end
      send_tile(K, 2, -1);
    end
    wait_idle();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    chk("all expected rows delivered", 64'(exp_v.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
